// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited issue to a fixed-latency IMEM,
// tag pipe matching the memory latency, and a prefetch FIFO towards decode.
module instr_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hlt,
  input  logic                        redir,
  input  logic [ADDR_W-1:0]           redir_pc,
  output logic                        imem_en,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [DATA_W-1:0]           imem_dout,
  output logic                        ir_valid,
  output logic [DATA_W-1:0]           ir,
  output logic [ADDR_W-1:0]           ir_pc,
  input  logic                        ir_ready,
  output logic [$clog2(DEPTH+1)-1:0]  occ
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IFL_W = $clog2(MEM_LAT + 1);
  localparam int CRD_W = $clog2(DEPTH + MEM_LAT + 1);

  logic [ADDR_W-1:0] pc;
  logic [MEM_LAT-1:0] tag_vld;
  logic [ADDR_W-1:0] tag_pc [MEM_LAT];

  logic [DATA_W-1:0] fifo_ir [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ_q;

  logic [IFL_W-1:0] inflight;
  logic [CRD_W-1:0] credit;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + IFL_W'(tag_vld[i]);
    end
  end

  // Every issued read holds a FIFO slot from issue until pop, so the FIFO can never overflow.
  assign credit    = CRD_W'(occ_q) + CRD_W'(inflight);
  assign imem_en   = rst & ~hlt & ~redir & (credit < CRD_W'(DEPTH));
  assign imem_addr = pc;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign push  = tag_vld[MEM_LAT-1] & ~redir;
  assign pop   = ~empty & ir_ready & ~redir;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redir) begin
      pc <= redir_pc;
    end else if (imem_en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || redir) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= imem_en;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_pc[0] <= pc;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_pc[i] <= tag_pc[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir[wr_ptr] <= imem_dout;
      fifo_pc[wr_ptr] <= tag_pc[MEM_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || redir) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Outputs read as zero while empty, so nothing stale is visible after reset or flush.
  assign ir_valid = ~empty;
  assign ir       = empty ? '0 : fifo_ir[rd_ptr];
  assign ir_pc    = empty ? '0 : fifo_pc[rd_ptr];
  assign occ      = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (!full || pop));

endmodule
